// File: rtl/riscv_test_monitor_pkg.sv
// Shared definitions for the riscv-tests pass/fail monitor: channel state
// encodings, exit-code constants and default addresses.
package riscv_test_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_PASS    = 3'd2;
  localparam logic [2:0] ST_FAIL    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  localparam int unsigned PASS_CODE       = 1;
  localparam int unsigned GP_REG_DEF      = 3;
  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h8000_1000;

  function automatic logic is_terminal(input logic [2:0] s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/riscv_test_monitor_if.sv
// Bundle of per-core retire/store taps feeding the monitor plus its verdict
// outputs; slave is the monitor side, master the core/bench side.
interface riscv_test_monitor_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NUM_CH = 1
);
  logic                     start;
  logic [NUM_CH-1:0]        wb_en;
  logic [5*NUM_CH-1:0]      wb_rd;
  logic [XLEN*NUM_CH-1:0]   wb_data;
  logic [NUM_CH-1:0]        ecall_ret;
  logic [NUM_CH-1:0]        st_en;
  logic [XLEN*NUM_CH-1:0]   st_addr;
  logic [XLEN*NUM_CH-1:0]   st_data;
  logic [NUM_CH-1:0]        ch_done;
  logic                     done;
  logic                     pass;
  logic                     fail;
  logic [2:0]               fail_ch;
  logic [XLEN-2:0]          fail_test;
  logic [31:0]              cycles;

  modport slave (
    input  start, wb_en, wb_rd, wb_data, ecall_ret, st_en, st_addr, st_data,
    output ch_done, done, pass, fail, fail_ch, fail_test, cycles
  );

  modport master (
    output start, wb_en, wb_rd, wb_data, ecall_ret, st_en, st_addr, st_data,
    input  ch_done, done, pass, fail, fail_ch, fail_test, cycles
  );
endinterface

// File: rtl/riscv_test_monitor_ch.sv
// One monitored core: run/verdict FSM, shadow copy of gp, watchdog counter
// and captured TESTNUM. Exposes next-state so the top can register aggregates
// on the same edge as the channel state.
module riscv_test_monitor_ch
  import riscv_test_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     MODE        = 0,
  parameter int unsigned     GP_REG      = GP_REG_DEF,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(TOHOST_ADDR_DEF),
  parameter int unsigned     TIMEOUT     = 500
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            ecall_ret_i,
  input  logic            st_en_i,
  input  logic [XLEN-1:0] st_addr_i,
  input  logic [XLEN-1:0] st_data_i,
  output logic [2:0]      state_o,
  output logic [2:0]      state_d_o,
  output logic [XLEN-2:0] code_d_o
);

  localparam logic [4:0]      GP_IDX  = 5'(GP_REG);
  localparam logic [XLEN-1:0] PASS_V  = XLEN'(PASS_CODE);
  localparam logic [31:0]     TO_LAST = 32'(TIMEOUT - 1);

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] shadow_q, shadow_d;
  logic [31:0]     count_q, count_d;
  logic [XLEN-2:0] code_q, code_d;

  logic            gp_wr;
  logic            ev;
  logic [XLEN-1:0] val;
  logic            ev_pass, ev_fail;

  // x0 is hardwired, so a GP_REG of 0 never produces a shadow update.
  assign gp_wr = (GP_IDX != 5'd0) && wb_en_i && (wb_rd_i == GP_IDX);

  // The ecall sees a gp write retiring in the same cycle ahead of the shadow.
  assign ev  = (MODE == 1) ? (st_en_i && (st_addr_i == TOHOST_ADDR)) : ecall_ret_i;
  assign val = (MODE == 1) ? st_data_i : (gp_wr ? wb_data_i : shadow_q);

  assign ev_pass = ev && (val == PASS_V);
  assign ev_fail = ev && val[0] && (val != PASS_V);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    code_d   = code_q;
    case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        if (start_i) begin
          state_d  = ST_RUN;
          shadow_d = '0;
          count_d  = '0;
          code_d   = '0;
        end
      end
      ST_RUN: begin
        count_d = count_q + 32'd1;
        if (gp_wr) shadow_d = wb_data_i;
        if (ev_pass) begin
          state_d = ST_PASS;
        end else if (ev_fail) begin
          state_d = ST_FAIL;
          code_d  = val[XLEN-1:1];
        end else if (count_q == TO_LAST) begin
          state_d = ST_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      count_q  <= '0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
      code_q   <= code_d;
    end
  end

  assign state_o   = state_q;
  assign state_d_o = state_d;
  assign code_d_o  = code_d;

endmodule

// File: rtl/riscv_test_monitor.sv
// riscv-tests exit-code monitor across NUM_CH cores: per-channel verdicts,
// sticky aggregate pass/fail, lowest failing channel and a run cycle counter.
module riscv_test_monitor
  import riscv_test_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     NUM_CH      = 1,
  parameter int unsigned     MODE        = 0,
  parameter int unsigned     GP_REG      = GP_REG_DEF,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(TOHOST_ADDR_DEF),
  parameter int unsigned     TIMEOUT     = 500
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  riscv_test_monitor_if.slave  mon
);

  logic [2:0]      st_q   [NUM_CH];
  logic [2:0]      st_d   [NUM_CH];
  logic [XLEN-2:0] code_d [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    riscv_test_monitor_ch #(
      .XLEN        (XLEN),
      .MODE        (MODE),
      .GP_REG      (GP_REG),
      .TOHOST_ADDR (TOHOST_ADDR),
      .TIMEOUT     (TIMEOUT)
    ) u_ch (
      .clk_i       (sys_clk),
      .rst_ni      (sys_rst_n),
      .start_i     (mon.start),
      .wb_en_i     (mon.wb_en[i]),
      .wb_rd_i     (mon.wb_rd[5*i +: 5]),
      .wb_data_i   (mon.wb_data[XLEN*i +: XLEN]),
      .ecall_ret_i (mon.ecall_ret[i]),
      .st_en_i     (mon.st_en[i]),
      .st_addr_i   (mon.st_addr[XLEN*i +: XLEN]),
      .st_data_i   (mon.st_data[XLEN*i +: XLEN]),
      .state_o     (st_q[i]),
      .state_d_o   (st_d[i]),
      .code_d_o    (code_d[i])
    );
  end

  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            fail_q, fail_d;
  logic [2:0]      fail_ch_q, fail_ch_d;
  logic [XLEN-2:0] fail_test_q, fail_test_d;
  logic [31:0]     cycles_q, cycles_d;
  logic [NUM_CH-1:0] ch_done;
  logic            all_pass, any_run, any_arm;

  // Aggregates are built from channel next-state so they land on the same
  // edge as the channel verdict; the first failing index wins the encoder.
  always_comb begin
    done_d      = 1'b1;
    all_pass    = 1'b1;
    fail_d      = 1'b0;
    fail_ch_d   = '0;
    fail_test_d = '0;
    any_run     = 1'b0;
    any_arm     = 1'b0;
    ch_done     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_done[i] = is_terminal(st_q[i]);
      if (!is_terminal(st_d[i])) done_d = 1'b0;
      if (st_d[i] != ST_PASS) all_pass = 1'b0;
      if (st_q[i] == ST_RUN) any_run = 1'b1;
      else                   any_arm = 1'b1;
      if (!fail_d && (st_d[i] == ST_FAIL || st_d[i] == ST_TIMEOUT)) begin
        fail_d      = 1'b1;
        fail_ch_d   = 3'(i);
        fail_test_d = code_d[i];
      end
    end
    pass_d = done_d && all_pass;
  end

  always_comb begin
    cycles_d = cycles_q;
    if (mon.start && any_arm) cycles_d = '0;
    else if (any_run && (cycles_q != '1)) cycles_d = cycles_q + 32'd1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_ch_q   <= '0;
      fail_test_q <= '0;
      cycles_q    <= '0;
    end else begin
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      fail_ch_q   <= fail_ch_d;
      fail_test_q <= fail_test_d;
      cycles_q    <= cycles_d;
    end
  end

  assign mon.ch_done   = ch_done;
  assign mon.done      = done_q;
  assign mon.pass      = pass_q;
  assign mon.fail      = fail_q;
  assign mon.fail_ch   = fail_ch_q;
  assign mon.fail_test = fail_test_q;
  assign mon.cycles    = cycles_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Self-checking bench: MODE0 single core and MODE1 dual core monitors, with
// expected verdicts queued at stimulus time and checked when done rises.
module tb_riscv_test_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  riscv_test_monitor_if #(.XLEN(32), .NUM_CH(1)) if0 ();
  riscv_test_monitor_if #(.XLEN(32), .NUM_CH(2)) if1 ();

  riscv_test_monitor #(
    .XLEN(32), .NUM_CH(1), .MODE(0), .GP_REG(3),
    .TOHOST_ADDR(32'h8000_1000), .TIMEOUT(500)
  ) dut0 (.sys_clk(clk), .sys_rst_n(rst_n), .mon(if0.slave));

  riscv_test_monitor #(
    .XLEN(32), .NUM_CH(2), .MODE(1), .GP_REG(3),
    .TOHOST_ADDR(32'h8000_1000), .TIMEOUT(500)
  ) dut1 (.sys_clk(clk), .sys_rst_n(rst_n), .mon(if1.slave));

  typedef struct {
    logic        pass;
    logic        fail;
    logic [2:0]  fch;
    logic [30:0] ftest;
    logic [31:0] cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if0.start = 1'b0; if0.wb_en = '0; if0.wb_rd = '0; if0.wb_data = '0;
    if0.ecall_ret = '0; if0.st_en = '0; if0.st_addr = '0; if0.st_data = '0;
    if1.start = 1'b0; if1.wb_en = '0; if1.wb_rd = '0; if1.wb_data = '0;
    if1.ecall_ret = '0; if1.st_en = '0; if1.st_addr = '0; if1.st_data = '0;
  endtask

  task automatic push(input int sel, input logic p, input logic f, input logic [2:0] fc,
                      input logic [30:0] ft, input logic [31:0] cy);
    exp_t e;
    e.pass = p; e.fail = f; e.fch = fc; e.ftest = ft; e.cyc = cy;
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  // Core-0 regfile write of x<rd> plus optional ecall retire, one cycle.
  task automatic core0(input logic [4:0] rd, input logic [31:0] data, input logic wen,
                       input logic ecall);
    if0.wb_en = wen; if0.wb_rd = rd; if0.wb_data = data; if0.ecall_ret = ecall;
    tick();
    idle_inputs();
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 0) if0.start = 1'b1;
    else          if1.start = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic wait_check(input int sel, input string tag);
    logic seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if ((sel == 0) ? if0.done : if1.done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, ".done"}, 64'(seen), 64'd1);
    if ((sel == 0 ? q0.size() : q1.size()) == 0) begin
      chk({tag, ".sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = (sel == 0) ? q0.pop_front() : q1.pop_front();
      if (sel == 0) begin
        chk({tag, ".pass"},  64'(if0.pass),      64'(e.pass));
        chk({tag, ".fail"},  64'(if0.fail),      64'(e.fail));
        chk({tag, ".fch"},   64'(if0.fail_ch),   64'(e.fch));
        chk({tag, ".ftest"}, 64'(if0.fail_test), 64'(e.ftest));
        chk({tag, ".cyc"},   64'(if0.cycles),    64'(e.cyc));
      end else begin
        chk({tag, ".pass"},  64'(if1.pass),      64'(e.pass));
        chk({tag, ".fail"},  64'(if1.fail),      64'(e.fail));
        chk({tag, ".fch"},   64'(if1.fail_ch),   64'(e.fch));
        chk({tag, ".ftest"}, 64'(if1.fail_test), 64'(e.ftest));
        chk({tag, ".cyc"},   64'(if1.cycles),    64'(e.cyc));
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ch_done0"}, 64'(if0.ch_done),   64'd0);
    chk({tag, ".done0"},    64'(if0.done),      64'd0);
    chk({tag, ".pass0"},    64'(if0.pass),      64'd0);
    chk({tag, ".fail0"},    64'(if0.fail),      64'd0);
    chk({tag, ".cyc0"},     64'(if0.cycles),    64'd0);
    chk({tag, ".ch_done1"}, 64'(if1.ch_done),   64'd0);
    chk({tag, ".fail1"},    64'(if1.fail),      64'd0);
    chk({tag, ".fch1"},     64'(if1.fail_ch),   64'd0);
    chk({tag, ".ftest1"},   64'(if1.fail_test), 64'd0);
    chk({tag, ".cyc1"},     64'(if1.cycles),    64'd0);
  endtask

  initial begin
    idle_inputs();
    repeat (3) tick();
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // gp=2 + ecall is non-terminal; gp=1 + ecall passes; x4 writes ignored.
    pulse_start(0);
    core0(5'd3, 32'd2, 1'b1, 1'b0);
    core0(5'd4, 32'd1, 1'b1, 1'b1);
    chk("t1.even_ecall", 64'(if0.ch_done), 64'd0);
    core0(5'd3, 32'd1, 1'b1, 1'b0);
    push(0, 1'b1, 1'b0, 3'd0, 31'd0, 32'd4);
    core0(5'd0, 32'd0, 1'b0, 1'b1);
    wait_check(0, "t1");
    chk("t1.ch_done", 64'(if0.ch_done), 64'd1);
    repeat (5) tick();
    chk("t1.frozen", 64'(if0.cycles), 64'd4);

    // Re-arm from PASS, then fail code 5 written in the same cycle as ecall.
    pulse_start(0);
    chk("t6.ch_done", 64'(if0.ch_done), 64'd0);
    chk("t6.pass",    64'(if0.pass),    64'd0);
    push(0, 1'b0, 1'b1, 3'd0, 31'd2, 32'd1);
    core0(5'd3, 32'd5, 1'b1, 1'b1);
    wait_check(0, "t2");

    pulse_start(0);
    core0(5'd3, 32'd1, 1'b1, 1'b0);
    push(0, 1'b1, 1'b0, 3'd0, 31'd0, 32'd2);
    core0(5'd0, 32'd0, 1'b0, 1'b1);
    wait_check(0, "t6");

    // Watchdog expiry after 500 RUN cycles.
    pulse_start(0);
    repeat (499) tick();
    chk("t3.pre_to", 64'(if0.ch_done), 64'd0);
    push(0, 1'b0, 1'b1, 3'd0, 31'd0, 32'd500);
    tick();
    wait_check(0, "t3.to");

    // A verdict on the expiry cycle beats the timeout.
    pulse_start(0);
    repeat (499) tick();
    push(0, 1'b1, 1'b0, 3'd0, 31'd0, 32'd500);
    core0(5'd3, 32'd1, 1'b1, 1'b1);
    wait_check(0, "t3.win");

    // MODE1 dual channel: wrong address and even codes ignored.
    pulse_start(1);
    if1.st_en = 2'b11;
    if1.st_addr = {32'h8000_1000, 32'h8000_1004};
    if1.st_data = {32'd2, 32'd1};
    tick(); idle_inputs();
    chk("t4.ignored", 64'(if1.ch_done), 64'd0);
    if1.st_en = 2'b01; if1.st_addr = {32'h0, 32'h8000_1000}; if1.st_data = {32'h0, 32'd1};
    tick(); idle_inputs();
    chk("t4.ch0_done", 64'(if1.ch_done), 64'd1);
    chk("t4.not_done", 64'(if1.done),    64'd0);
    if1.st_en = 2'b10; if1.st_addr = {32'h8000_1000, 32'h0}; if1.st_data = {32'd7, 32'h0};
    push(1, 1'b0, 1'b1, 3'd1, 31'd3, 32'd3);
    tick(); idle_inputs();
    wait_check(1, "t4");
    chk("t4.ch_done", 64'(if1.ch_done), 64'd3);

    // Asynchronous reset in the middle of a run and with a held verdict.
    pulse_start(0);
    repeat (3) tick();
    chk("t5.pre_cyc", 64'(if0.cycles), 64'd3);
    #5;
    rst_n = 1'b0;
    #1;
    chk_zero("t5.async");
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start(0);
    push(0, 1'b1, 1'b0, 3'd0, 31'd0, 32'd1);
    core0(5'd3, 32'd1, 1'b1, 1'b1);
    wait_check(0, "t5.fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
